// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: key event pop handshake between decoder (master) and reader (slave)
interface ps2_scancode_decoder_if;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready;
    modport master (output key_code, key_ext, key_break, key_valid, input key_ready);
    modport slave (input key_code, key_ext, key_break, key_valid, output key_ready);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set-2 prefix decoder (E0/F0/E1) feeding a key event FIFO with pop handshake
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   ps2_data,
    input  logic                         ps2_valid,
    input  logic                         ps2_err,
    ps2_scancode_decoder_if.master       key,
    output logic [CW-1:0]                count,
    output logic                         overflow,
    output logic                         proto_err,
    input  logic                         clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
    state_t st, nxt;
    logic [2:0] pcnt, ncnt;
    logic [9:0] ev;
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic push, bad, pop, push_ok, full, pfx;
    assign pfx = ps2_data inside {8'hE0, 8'hE1, 8'hF0};
    always_comb begin
        nxt = st;
        ncnt = pcnt;
        push = 1'b0;
        ev = {ps2_data, 2'b00};
        bad = 1'b0;
        if (ps2_valid && ps2_err) begin
            nxt = IDLE;
            ncnt = '0;
            bad = 1'b1;
        end else if (ps2_valid) begin
            case (st)
                IDLE:
                    if (ps2_data == 8'hE0) nxt = EXT;
                    else if (ps2_data == 8'hF0) nxt = BRK;
                    else if (ps2_data == 8'hE1) begin
                        nxt = PAUSE;
                        ncnt = 3'd7;
                    end else if (ps2_data == 8'h00 || ps2_data == 8'hFF) bad = 1'b1;
                    else push = 1'b1;
                EXT:
                    if (ps2_data == 8'hF0) nxt = EXT_BRK;
                    else if (ps2_data == 8'hE1) begin
                        nxt = IDLE;
                        bad = 1'b1;
                    end else if (ps2_data != 8'hE0) begin
                        nxt = IDLE;
                        push = 1'b1;
                        ev = {ps2_data, 2'b10};
                    end
                BRK, EXT_BRK: begin
                    nxt = IDLE;
                    bad = pfx;
                    push = ~pfx;
                    ev = {ps2_data, st == EXT_BRK, 1'b1};
                end
                PAUSE: begin
                    // Pause bytes are counted, never inspected
                    ncnt = pcnt - 3'd1;
                    if (pcnt == 3'd1) begin
                        nxt = IDLE;
                        push = 1'b1;
                        ev = {8'hE1, 2'b00};
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end
    assign key.key_valid = count != '0;
    assign full = count == CW'(FIFO_DEPTH);
    assign pop = key.key_valid & key.key_ready;
    assign push_ok = push & (~full | pop);
    assign {key.key_code, key.key_ext, key.key_break} = key.key_valid ? mem[rp] : 10'd0;
    always_ff @(posedge clk)
        if (push_ok) mem[wp] <= ev;
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            pcnt <= '0;
            wp <= '0;
            rp <= '0;
            count <= '0;
            overflow <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            st <= nxt;
            pcnt <= ncnt;
            wp <= wp + AW'(push_ok);
            rp <= rp + AW'(pop);
            count <= count + CW'(push_ok) - CW'(pop);
            overflow <= (push & ~push_ok) | (overflow & ~clr_err);
            proto_err <= bad | (proto_err & ~clr_err);
        end
    end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream produced by `ps2_controller` (one `valid` pulse per received PS/2 frame, `err` on framing/parity failure). It decodes Set-2 scancode prefixes (0xE0 extended, 0xF0 break, 0xE1 Pause) into single key events and buffers them in a FIFO. A bus peripheral or CPU-side reader drains the FIFO with a valid/ready pop handshake.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO depth; power of two, ≥2.
- `CW`, default $clog2(FIFO_DEPTH)+1: width of `count`; derived, not overridden.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `ps2_data`  in  8  byte from `ps2_controller.data`.
- `ps2_valid`  in  1  one-cycle strobe from `ps2_controller.valid`.
- `ps2_err`  in  1  from `ps2_controller.err`; qualified by `ps2_valid`.
- `key_code`  out  8  FIFO head scancode; 0x00 when empty.
- `key_ext`  out  1  FIFO head extended flag; 0 when empty.
- `key_break`  out  1  FIFO head release flag; 0 when empty.
- `key_valid`  out  1  FIFO non-empty.
- `key_ready`  in  1  pop request; pops when `key_valid & key_ready`.
- `count`  out  CW  events in FIFO, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky: event dropped because FIFO full.
- `proto_err`  out  1  sticky: bad frame or illegal prefix sequence.
- `clr_err`  in  1  clears `overflow` and `proto_err`.

## Operation
- Byte accepted only when `ps2_valid & ~ps2_err`. If `ps2_valid & ps2_err`: byte discarded, FSM → IDLE, pause counter cleared, `proto_err` set.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur on accepted bytes only:
  - IDLE: E0→EXT; F0→BRK; E1→PAUSE (skip counter := 7); 0x00 or 0xFF (keyboard overrun) → discard, set `proto_err`; other → emit {code, ext=0, brk=0}.
  - EXT: F0→EXT_BRK; E0→stay EXT; E1→IDLE + `proto_err`; other → emit {code, 1, 0}, →IDLE.
  - BRK: E0/E1/F0 → IDLE + `proto_err`, nothing emitted; other → emit {code, 0, 1}, →IDLE.
  - EXT_BRK: E0/E1/F0 → IDLE + `proto_err`; other → emit {code, 1, 1}, →IDLE.
  - PAUSE: every byte decrements the counter with no content check. The byte that brings it to 0 emits {0xE1, 0, 0} and returns to IDLE. Full sequence: E1 14 77 E1 F0 14 F0 77.
- FIFO: a push is accepted when `count < FIFO_DEPTH` or a pop occurs in the same cycle. Otherwise the event is dropped, `overflow` is set, and FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- Pop when empty is ignored. Simultaneous push and pop leaves `count` unchanged.
- Sticky flags: `clr_err` clears them. A set condition in the same cycle as `clr_err` wins, so the flag stays 1.
- `rst`: FSM → IDLE, counter 0, FIFO empty, `count`=0, `key_valid`=0, `key_code`=0x00, `key_ext`=0, `key_break`=0, `overflow`=0, `proto_err`=0. A partial prefix sequence is lost.

## Timing
- Decode and push happen at the rising edge where `ps2_valid` is sampled. The event is visible on `key_*` and `count` on the following cycle (1-cycle latency, no fall-through).
- Head outputs are driven from the FIFO read pointer. After a pop edge, the next entry (or zeros if empty) appears in the same cycle the pointer updates.
- Back-to-back `ps2_valid` pulses on consecutive cycles are supported.
- Sticky flags rise one cycle after the causing event.

## Test plan
- Reset, then byte 0x1C → next cycle `key_valid`=1, `key_code`=0x1C, ext=0, brk=0, `count`=1. Pop with `key_ready` → `count`=0 and outputs return to zeros.
- Sequences F0 1C, E0 74, E0 F0 74 → three events in order: {1C,0,1}, {74,1,0}, {74,1,1}; `proto_err`=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,0}. Then byte 0x1C → {1C,0,0}.
- Send 9 make codes 0x01..0x09 with no pops (depth 8) → `count`=8, `overflow`=1, pops return 0x01..0x08. Then on a full FIFO, push and pop in the same cycle → `count` stays 8 and no new overflow. Then `clr_err` → `overflow`=0.
- Send E0, then `ps2_valid` with `ps2_err`, then 0x1C → `proto_err`=1 and the event is {1C,0,0}. Send F0 F0 → `proto_err` set and no event.
- Send F0, assert `rst` one cycle, then send 0x1C → event {1C,0,1} is not produced; {1C,0,0} is produced instead.
